voice_allocator: RTL
====================

// Module: voice_allocator
// PURPOSE
//  Parametrised polyphonic front end between the debounced button bus and channel_mixer.
//  Assigns key presses to NUM_VOICES mixer channels with oldest-voice stealing.
//  Latches a per-voice waveform at note-on and arbitrates PLAY/DEMO modes.
//  Drives registered channel_ena/pitches/waveforms; demo_decoder data passes through in DEMO.
// PARAMETERS
//  NUM_KEYS    8   key inputs (bus width of keys, key_pitches)
//  NUM_VOICES  4   mixer channels driven; must be >=1
//  PITCH_W     12  pitch divider width per channel (matches channel_mixer C)
//  AGE_W       4   per-voice age counter width; saturates at 2**AGE_W-1
// PORTS
//  clk               in   1                     system clock
//  rst               in   1                     asynchronous, active-low reset
//  keys              in   NUM_KEYS              debounced key levels, 1 = pressed
//  key_pitches       in   NUM_KEYS*PITCH_W      pitch divider for key k at [k*PITCH_W +: PITCH_W]
//  waveform_sel      in   2                     current waveform, sampled at note-on
//  demo_req          in   1                     1-cycle pulse: enter DEMO
//  demo_channel_ena  in   NUM_VOICES            from demo_decoder
//  demo_pitches      in   NUM_VOICES*PITCH_W    from demo_decoder
//  demo_waveforms    in   NUM_VOICES*2          from demo_decoder
//  channel_ena       out  NUM_VOICES            to channel_mixer, registered
//  pitches           out  NUM_VOICES*PITCH_W    to channel_mixer, registered
//  waveforms         out  NUM_VOICES*2          to channel_mixer, registered
//  demo_ena          out  1                     1 while in DEMO (demo_decoder ena, LED)
// BEHAVIOUR
//  Reset (rst=0, async): mode=PLAY; all outputs 0; pending, voices, ages cleared; key_q=0.
//  Edges: rise = keys & ~key_q, fall = ~keys & key_q; key_q <= keys every cycle.
//  FSM PLAY: demo_req -> DEMO, clears all voices and pending, demo_ena<=1.
//    demo_req wins over key edges in the same cycle.
//  FSM DEMO: outputs <= demo_* inputs each cycle (1-cycle latency).
//    Any rise -> PLAY. The exit press is consumed and never allocated; demo_ena<=0.
//    Further demo_req in DEMO is ignored.
//  PLAY per-cycle order:
//    (1) Releases: every voice whose key has a fall is freed (ena<=0) in this cycle.
//        A fall on a still-pending key clears its pending bit.
//    (2) Rises set pending bits.
//    (3) Allocate at most one key/cycle, lowest pending index first.
//        Target = lowest-index free voice, counting voices freed in (1).
//        If none is free: steal voice with max age; tie -> lowest index.
//        The stolen key gets no voice on its later release.
//  Allocation: voice.key<=k; pitch<=key_pitches[k]; wave<=waveform_sel; ena<=1; age<=0.
//    Every other active voice: age+1, saturating.
//  Latency: lone press sampled at edge N -> channel_ena high after edge N+1.
//    Simultaneous presses: +1 cycle each, in index order.
//  Released voice: ena=0 next edge; pitch/wave hold last value (mixer gates on ena).
//  Key held through stealing stays unallocated; no re-trigger until re-pressed.
//  NUM_KEYS < NUM_VOICES legal: upper voices never allocated unless free.
// CONFIGURATION
//  SUSTAIN_PEDAL_EN defined:
//    Adds port `sustain` (in, 1). While 1, a fall marks the voice sustained instead of freeing it.
//    On sustain 1->0, all sustained voices free in that cycle.
//    Sustained voices are still steal candidates by age.
//    A re-press of a key with a sustained voice allocates a new voice; the old one keeps sounding.
//  SUSTAIN_PEDAL_EN undefined: no sustain port; falls free immediately.
// TESTING
//  Reset mid-note: key0 held, rst=0 asynchronously -> channel_ena=0 and pitches=0 with no clock edge.
//  Single note: key2 press, key_pitches[2]=212, waveform_sel=1 ->
//    edge+2: channel_ena=4'b0001, pitch0=212, wave0=1. Release -> ena0=0 one edge later.
//  Chord + steal: NUM_VOICES=4, press keys 0..3 simultaneously ->
//    voices 0..3 filled on 4 consecutive cycles. Press key4 -> voice0 (age 3) stolen, pitch0=key4.
//  Release/alloc same cycle: voices full, key1 falls and key5 rises together ->
//    key5 takes key1's voice, no steal.
//  Mode: demo_req -> demo_ena=1, outputs track demo_* 1 cycle later.
//    key3 press -> PLAY, channel_ena=0, key3 not allocated.
//  Sustain (SUSTAIN_PEDAL_EN): sustain=1, press/release key0 -> ena0 stays 1.
//    sustain=0 -> ena0=0 next edge.

Source files
------------

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: registered mixer bus from voice_allocator to channel_mixer.
// One enable, one pitch divider and one 2-bit waveform per voice channel.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4,
  parameter int PITCH_W    = 12
);
  logic [NUM_VOICES-1:0]         channel_ena;
  logic [NUM_VOICES*PITCH_W-1:0] pitches;
  logic [NUM_VOICES*2-1:0]       waveforms;

  modport master (output channel_ena, pitches, waveforms);
  modport slave  (input  channel_ena, pitches, waveforms);
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic front end between the debounced key bus and channel_mixer.
// Assigns key presses to NUM_VOICES channels with oldest-voice stealing, latches a
// waveform per voice at note-on, and switches between PLAY and DEMO modes.
// Optional feature: define SUSTAIN_PEDAL_EN to add the `sustain` pedal input.
module voice_allocator #(
  parameter int NUM_KEYS   = 8,
  parameter int NUM_VOICES = 4,
  parameter int PITCH_W    = 12,
  parameter int AGE_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KEYS-1:0]           keys,
  input  logic [NUM_KEYS*PITCH_W-1:0]   key_pitches,
  input  logic [1:0]                    waveform_sel,
  input  logic                          demo_req,
  input  logic [NUM_VOICES-1:0]         demo_channel_ena,
  input  logic [NUM_VOICES*PITCH_W-1:0] demo_pitches,
  input  logic [NUM_VOICES*2-1:0]       demo_waveforms,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                          sustain,
`endif
  output logic                          demo_ena,
  voice_allocator_if.master             mix
);

  localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  localparam logic [0:0] MODE_PLAY = 1'b0;
  localparam logic [0:0] MODE_DEMO = 1'b1;

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  // Mode and key tracking
  logic [0:0]          mode_q, mode_n;
  logic                demo_ena_n;
  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] rise, fall;
  logic [NUM_KEYS-1:0] pending_q, pending_n;
  logic [NUM_KEYS-1:0] cand;

  // Per-voice state; ena/pitch/wave registers drive the mixer bus directly
  logic [NUM_VOICES-1:0]              ena_q, ena_n;
  logic [NUM_VOICES-1:0]              sus_q, sus_n;
  logic [NUM_VOICES-1:0][KEY_W-1:0]   vkey_q, vkey_n;
  logic [NUM_VOICES-1:0][AGE_W-1:0]   age_q, age_n;
  logic [NUM_VOICES-1:0][PITCH_W-1:0] pitch_q, pitch_n;
  logic [NUM_VOICES-1:0][1:0]         wave_q, wave_n;

  // Release and allocation decisions for the current cycle
  logic [NUM_VOICES-1:0] released;
  logic [NUM_VOICES-1:0] sus_mark;
  logic [NUM_VOICES-1:0] free_v;
  logic                  alloc_valid;
  int                    alloc_key;
  logic                  free_found;
  int                    target;
  logic [AGE_W-1:0]      best_age;

  // Pedal level and its falling edge
  logic sus_level;
  logic sus_drop;

  assign rise = keys & ~key_q;
  assign fall = ~keys & key_q;

`ifdef SUSTAIN_PEDAL_EN
  logic sustain_q;

  // Remember the previous pedal level so a pedal release can be detected
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sustain_q <= 1'b0;
    end else begin
      sustain_q <= sustain;
    end
  end

  assign sus_level = sustain;
  assign sus_drop  = sustain_q & ~sustain;
`else
  assign sus_level = 1'b0;
  assign sus_drop  = 1'b0;
`endif

  // Decide which sounding voices stop this cycle: a key release frees its voice
  // unless the pedal is down, and a pedal release frees every sustained voice
  always_comb begin
    released = '0;
    sus_mark = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (ena_q[v] && !sus_q[v] && fall[vkey_q[v]]) begin
        if (sus_level) begin
          sus_mark[v] = 1'b1;
        end else begin
          released[v] = 1'b1;
        end
      end
      if (sus_q[v] && sus_drop) begin
        released[v] = 1'b1;
      end
    end
  end

  // Pick the lowest-index pending key that is still held this cycle
  always_comb begin
    cand        = pending_q & ~fall;
    alloc_valid = 1'b0;
    alloc_key   = 0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!alloc_valid && cand[k]) begin
        alloc_valid = 1'b1;
        alloc_key   = k;
      end
    end
  end

  // Pick the target voice: lowest free voice (including ones freed this cycle),
  // otherwise the oldest voice with ties going to the lowest index
  always_comb begin
    free_v     = ~ena_q | released;
    free_found = 1'b0;
    target     = 0;
    best_age   = age_q[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!free_found && free_v[v]) begin
        free_found = 1'b1;
        target     = v;
      end
    end
    if (!free_found) begin
      for (int v = 1; v < NUM_VOICES; v++) begin
        if (age_q[v] > best_age) begin
          best_age = age_q[v];
          target   = v;
        end
      end
    end
  end

  // Next-state logic for mode, pending keys and all voice registers
  always_comb begin
    mode_n     = mode_q;
    demo_ena_n = demo_ena;
    pending_n  = pending_q;
    ena_n      = ena_q;
    sus_n      = sus_q;
    vkey_n     = vkey_q;
    age_n      = age_q;
    pitch_n    = pitch_q;
    wave_n     = wave_q;

    if (mode_q == MODE_PLAY) begin
      if (demo_req) begin
        mode_n     = MODE_DEMO;
        demo_ena_n = 1'b1;
        pending_n  = '0;
        ena_n      = '0;
        sus_n      = '0;
        age_n      = '0;
      end else begin
        ena_n     = ena_q & ~released;
        sus_n     = (sus_q & ~released) | sus_mark;
        pending_n = cand | rise;
        if (alloc_valid) begin
          pending_n[alloc_key] = 1'b0;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (v == target) begin
              vkey_n[v]  = KEY_W'(alloc_key);
              pitch_n[v] = key_pitches[alloc_key*PITCH_W +: PITCH_W];
              wave_n[v]  = waveform_sel;
              ena_n[v]   = 1'b1;
              sus_n[v]   = 1'b0;
              age_n[v]   = '0;
            end else if (ena_n[v] && age_q[v] != AGE_MAX) begin
              age_n[v] = age_q[v] + 1'b1;
            end
          end
        end
      end
    end else begin
      ena_n     = demo_channel_ena;
      pitch_n   = demo_pitches;
      wave_n    = demo_waveforms;
      pending_n = '0;
      sus_n     = '0;
      age_n     = '0;
      if (|rise) begin
        mode_n     = MODE_PLAY;
        demo_ena_n = 1'b0;
        ena_n      = '0;
      end
    end
  end

  // State registers; everything clears asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_PLAY;
      demo_ena  <= 1'b0;
      key_q     <= '0;
      pending_q <= '0;
      ena_q     <= '0;
      sus_q     <= '0;
      vkey_q    <= '0;
      age_q     <= '0;
      pitch_q   <= '0;
      wave_q    <= '0;
    end else begin
      mode_q    <= mode_n;
      demo_ena  <= demo_ena_n;
      key_q     <= keys;
      pending_q <= pending_n;
      ena_q     <= ena_n;
      sus_q     <= sus_n;
      vkey_q    <= vkey_n;
      age_q     <= age_n;
      pitch_q   <= pitch_n;
      wave_q    <= wave_n;
    end
  end

  assign mix.channel_ena = ena_q;
  assign mix.pitches     = pitch_q;
  assign mix.waveforms   = wave_q;

endmodule
